// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw pin, filters bounce with a
// stability counter and emits registered press/release/long-press strobes.
`timescale 1ns/1ps
module button_debouncer #(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 50000,
   parameter int unsigned LONG_PRESS_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESSING,
      PRESSED,
      RELEASING
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   cnt_done;
   logic                   rel_now;
   state_e                 state_q;
   logic [CW-1:0]          cnt_q;
   logic                   level_q;
   logic                   press_q;
   logic                   release_q;
   logic [HW-1:0]          hold_q;
   logic                   long_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign cnt_done = (cnt_q == CNT_LAST);
   // A release toggling on this edge suppresses a coincident long strobe.
   assign rel_now  = level_q & ~s & cnt_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            RELEASED, PRESSING: begin
               if (!s) begin
                  cnt_q   <= '0;
                  state_q <= RELEASED;
               end else if (cnt_done) begin
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
                  state_q <= PRESSED;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= PRESSING;
               end
            end
            PRESSED, RELEASING: begin
               if (s) begin
                  cnt_q   <= '0;
                  state_q <= PRESSED;
               end else if (cnt_done) begin
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  state_q   <= RELEASED;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= RELEASING;
               end
            end
            default: begin
               cnt_q   <= '0;
               level_q <= 1'b0;
               state_q <= RELEASED;
            end
         endcase
      end
   end

   // Hold counter saturates at the threshold so the long strobe fires once per press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (!level_q) begin
            hold_q <= '0;
         end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HW'(1);
            long_q <= (hold_q == HOLD_LAST) & ~rel_now;
         end
      end
   end

   assign btn_level        = level_q;
   assign press_pulse      = press_q;
   assign release_pulse    = release_q;
   assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing input,
// checked every cycle against a sample-window reference model.
`timescale 1ns/1ps
module tb_button_debouncer;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LONG = 20;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic button = 1'b0;
   logic btn_level, press_pulse, release_pulse, long_press_pulse;

   int n_cmp = 0;
   int n_mis = 0;

   button_debouncer #(
      .SYNC_STAGES      (SYNC),
      .DEBOUNCE_CYCLES  (DEB),
      .LONG_PRESS_CYCLES(LONG)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .button          (button),
      .btn_level       (btn_level),
      .press_pulse     (press_pulse),
      .release_pulse   (release_pulse),
      .long_press_pulse(long_press_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: s is the pin sampled SYNC edges ago; the level flips once the
   // last DEB values of s all differ from it; long fires LONG edges after a rise.
   bit bq[$];
   bit sh[$];
   bit m_level, m_press, m_rel, m_long;
   int m_k = 0;
   int m_rise = -1000000;
   int m_npress = 0, m_nrel = 0, m_nlong = 0;

   function automatic void model_reset();
      bq.delete();
      sh.delete();
      m_level = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      m_rise  = -1000000;
   endfunction

   function automatic void model_step(bit b);
      bit s, lv0, tog;
      s = (bq.size() >= SYNC) ? bq[bq.size() - SYNC] : 1'b0;
      bq.push_back(b);
      if (bq.size() > 16) void'(bq.pop_front());
      sh.push_back(s);
      if (sh.size() > 16) void'(sh.pop_front());
      lv0 = m_level;
      tog = (sh.size() >= DEB);
      for (int i = 0; i < DEB; i++)
         if (tog && sh[sh.size() - 1 - i] == lv0) tog = 1'b0;
      m_press = tog && !lv0;
      m_rel   = tog && lv0;
      m_long  = lv0 && (m_k - m_rise == LONG) && !tog;
      if (tog) m_level = !lv0;
      if (m_press) m_rise = m_k;
      m_npress += int'(m_press);
      m_nrel   += int'(m_rel);
      m_nlong  += int'(m_long);
      m_k++;
   endfunction

   int ecnt = 0;
   int e_press = 0, e_rel = 0, e_long = 0;
   int n_press = 0, n_rel = 0, n_long = 0;

   // Called at a negedge; returns at the following negedge.
   task automatic tick(input logic b);
      button = b;
      @(posedge clk);
      model_step(b);
      #1;
      check("outs", {28'd0, btn_level, press_pulse, release_pulse, long_press_pulse},
                    {28'd0, m_level, m_press, m_rel, m_long});
      ecnt++;
      if (press_pulse)      begin n_press++; e_press = ecnt; end
      if (release_pulse)    begin n_rel++;   e_rel   = ecnt; end
      if (long_press_pulse) begin n_long++;  e_long  = ecnt; end
      @(negedge clk);
   endtask

   task automatic do_reset(input logic b);
      button = b;
      rst_n  = 1'b0;
      #1;
      check("rst_outs", {28'd0, btn_level, press_pulse, release_pulse, long_press_pulse}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int start, p0, r0, l0, len;
   logic b;

   initial begin
      @(negedge clk);
      do_reset(1'b0);
      repeat (8) tick(1'b0);

      // clean press
      start = ecnt; p0 = n_press;
      repeat (8) tick(1'b1);
      check("clean_lat", e_press - start, 6);
      check("clean_cnt", n_press - p0, 1);
      repeat (10) tick(1'b0);

      // bounce
      start = ecnt; p0 = n_press;
      tick(1'b1); tick(1'b1); tick(1'b0);
      repeat (10) tick(1'b1);
      check("bounce_lat", e_press - start, 9);
      check("bounce_cnt", n_press - p0, 1);
      repeat (10) tick(1'b0);

      // short glitch
      p0 = n_press; r0 = n_rel; l0 = n_long;
      repeat (3) tick(1'b1);
      repeat (10) tick(1'b0);
      check("glitch_pulses", (n_press - p0) + (n_rel - r0) + (n_long - l0), 0);
      check("glitch_level", btn_level, 1'b0);

      // long press then release
      p0 = n_press; l0 = n_long; r0 = n_rel;
      repeat (6) tick(1'b1);
      repeat (40) tick(1'b1);
      check("long_cnt", n_long - l0, 1);
      check("long_lat", e_long - e_press, 20);
      start = ecnt;
      repeat (10) tick(1'b0);
      check("long_rel_lat", e_rel - start, 6);
      check("long_rel_cnt", n_rel - r0, 1);

      // short press
      p0 = n_press; r0 = n_rel; l0 = n_long;
      repeat (15) tick(1'b1);
      repeat (10) tick(1'b0);
      check("short_press", n_press - p0, 1);
      check("short_rel", n_rel - r0, 1);
      check("short_long", n_long - l0, 0);

      // reset mid-press
      repeat (8) tick(1'b1);
      check("mid_level", btn_level, 1'b1);
      r0 = n_rel;
      do_reset(1'b1);
      start = ecnt;
      repeat (8) tick(1'b1);
      check("mid_norel", n_rel - r0, 0);
      check("mid_repress", e_press - start, 6);
      repeat (10) tick(1'b0);

      // random bouncing input with occasional resets
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 40) == 0) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 35))
                                              : int'($urandom_range(1, 6));
            repeat (len) tick(b);
         end
      end

      check("press_total", n_press, m_npress);
      check("rel_total", n_rel, m_nrel);
      check("long_total", n_long, m_nlong);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
